// File: rtl/perf_event_monitor.sv
// Performance-event monitor: cycle, retired-instruction and generic event
// counters with saturation, halt-terminated runs and a registered read port.
module perf_event_monitor #(
    parameter int CNT_W      = 32,
    parameter int NUM_EVT    = 4,
    parameter int HALT_LIMIT = 4,
    parameter int SEL_W      = $clog2(NUM_EVT + 2),
    parameter int HC_W       = $clog2(HALT_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  retire,
    input  logic                  halt,
    input  logic [NUM_EVT-1:0]    evt,
    input  logic                  rd_req,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  done,
    output logic                  running,
    output logic [HC_W-1:0]       halt_cnt,
    output logic [NUM_EVT+1:0]    ovf
);

    localparam int NUM_CNT = NUM_EVT + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [HC_W-1:0]  HALT_LAST = HC_W'(HALT_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [HC_W-1:0]      halt_cnt_r;
    logic                 done_r;
    logic                 running_r;
    logic [CNT_W-1:0]     cnt_r     [NUM_CNT];
    logic [CNT_W-1:0]     cnt_nxt_s [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_r;
    logic [NUM_CNT-1:0]   ovf_nxt_s;
    logic [NUM_CNT-1:0]   inc_s;
    logic                 count_en_s;
    logic [CNT_W-1:0]     rd_mux_s;
    logic [CNT_W-1:0]     rd_data_r;
    logic                 rd_valid_r;

    // Index 0 ticks every cycle, 1 is retire, 2+i is event channel i.
    assign inc_s      = {evt, retire, 1'b1};
    assign count_en_s = (state_r == ST_RUN);

    // Run-control FSM; done/running are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            halt_cnt_r <= '0;
            done_r     <= 1'b0;
            running_r  <= 1'b0;
        end else if (clear) begin
            state_r    <= ST_IDLE;
            halt_cnt_r <= '0;
            done_r     <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        halt_cnt_r <= halt_cnt_r + HC_W'(1);
                        if (halt_cnt_r == HALT_LAST) begin
                            state_r   <= ST_DONE;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    halt_cnt_r <= '0;
                    done_r     <= 1'b0;
                    running_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating next-count and sticky overflow for every counter.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            ovf_nxt_s[i] = ovf_r[i];
            if (clear) begin
                cnt_nxt_s[i] = '0;
                ovf_nxt_s[i] = 1'b0;
            end else if (count_en_s && inc_s[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    cnt_nxt_s[i] = cnt_r[i];
                    ovf_nxt_s[i] = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                    ovf_nxt_s[i] = ovf_r[i];
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
                ovf_nxt_s[i] = ovf_r[i];
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    // Read mux over current (pre-update) values; out-of-range selects give zero.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            rd_mux_s = rd_mux_s | ((int'(rd_sel) == i) ? cnt_r[i] : '0);
        end
    end

    // Read response register; data holds between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req) begin
                rd_data_r <= rd_mux_s;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign done     = done_r;
    assign running  = running_r;
    assign halt_cnt = halt_cnt_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed, table-driven bench for perf_event_monitor: a default instance,
// a CNT_W=4 instance for saturation and a HALT_LIMIT=1 instance, sharing stimulus.
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, retire, halt, rd_req;
    logic [3:0]  evt;
    logic [2:0]  rd_sel;

    logic        rd_valid_a, done_a, running_a;
    logic [31:0] rd_data_a;
    logic [2:0]  halt_cnt_a;
    logic [5:0]  ovf_a;

    logic        rd_valid_b, done_b, running_b;
    logic [3:0]  rd_data_b;
    logic [2:0]  halt_cnt_b;
    logic [5:0]  ovf_b;

    logic        rd_valid_c, done_c, running_c;
    logic [31:0] rd_data_c;
    logic [0:0]  halt_cnt_c;
    logic [5:0]  ovf_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_event_monitor u_dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
        .halt(halt), .evt(evt), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .done(done_a),
        .running(running_a), .halt_cnt(halt_cnt_a), .ovf(ovf_a)
    );

    perf_event_monitor #(.CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
        .halt(halt), .evt(evt), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .done(done_b),
        .running(running_b), .halt_cnt(halt_cnt_b), .ovf(ovf_b)
    );

    perf_event_monitor #(.HALT_LIMIT(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
        .halt(halt), .evt(evt), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid_c), .rd_data(rd_data_c), .done(done_c),
        .running(running_c), .halt_cnt(halt_cnt_c), .ovf(ovf_c)
    );

    typedef struct {
        logic        start, clear, retire, halt;
        logic [3:0]  evt;
        logic        rd_req;
        logic [2:0]  rd_sel;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_running, exp_done;
        logic [2:0]  exp_hc;
        logic        exp_done_c;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic st, input logic rt, input logic hl,
                                input logic [3:0] ev, input logic rq, input logic [2:0] sel,
                                input logic v, input logic [31:0] d, input logic run,
                                input logic dn, input logic [2:0] hc, input logic dc);
        vec_t t;
        t.start = st; t.clear = 1'b0; t.retire = rt; t.halt = hl; t.evt = ev;
        t.rd_req = rq; t.rd_sel = sel; t.exp_valid = v; t.exp_data = d;
        t.exp_running = run; t.exp_done = dn; t.exp_hc = hc; t.exp_done_c = dc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; clear = 1'b0; retire = 1'b0; halt = 1'b0;
        evt = 4'b0000; rd_req = 1'b0; rd_sel = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fin [6];
        fin[0] = 32'd10; fin[1] = 32'd6; fin[2] = 32'd3;
        fin[3] = 32'd3;  fin[4] = 32'd0; fin[5] = 32'd0;

        //              st   rt   hl   evt      rq   sel   v    data    run  dn   hc    dc
        tbl[0]  = mk(1'b0,1'b1,1'b1,4'b1111,1'b0,3'd0,1'b0,32'd0, 1'b0,1'b0,3'd0,1'b0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'd0,1'b1,32'd0, 1'b0,1'b0,3'd0,1'b0);
        tbl[2]  = mk(1'b1,1'b0,1'b0,4'b0000,1'b0,3'd0,1'b0,32'd0, 1'b1,1'b0,3'd0,1'b0);
        tbl[3]  = mk(1'b0,1'b1,1'b0,4'b0000,1'b0,3'd0,1'b0,32'd0, 1'b1,1'b0,3'd0,1'b0);
        tbl[4]  = mk(1'b0,1'b1,1'b0,4'b0011,1'b0,3'd0,1'b0,32'd0, 1'b1,1'b0,3'd0,1'b0);
        tbl[5]  = mk(1'b0,1'b1,1'b1,4'b0000,1'b0,3'd0,1'b0,32'd0, 1'b1,1'b0,3'd1,1'b1);
        tbl[6]  = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'd1,1'b1,32'd3, 1'b1,1'b0,3'd1,1'b1);
        tbl[7]  = mk(1'b0,1'b0,1'b1,4'b0011,1'b0,3'd0,1'b0,32'd3, 1'b1,1'b0,3'd2,1'b1);
        tbl[8]  = mk(1'b0,1'b1,1'b0,4'b0000,1'b1,3'd0,1'b1,32'd5, 1'b1,1'b0,3'd2,1'b1);
        tbl[9]  = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'd2,1'b1,32'd2, 1'b1,1'b0,3'd2,1'b1);
        tbl[10] = mk(1'b0,1'b1,1'b1,4'b0000,1'b0,3'd0,1'b0,32'd2, 1'b1,1'b0,3'd3,1'b1);
        tbl[11] = mk(1'b0,1'b0,1'b0,4'b0011,1'b0,3'd0,1'b0,32'd2, 1'b1,1'b0,3'd3,1'b1);
        tbl[12] = mk(1'b0,1'b1,1'b1,4'b0000,1'b0,3'd0,1'b0,32'd2, 1'b0,1'b1,3'd4,1'b1);
        for (int i = 0; i < 6; i++) begin
            tbl[13+i] = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'(i),1'b1,fin[i],1'b0,1'b1,3'd4,1'b1);
        end
        tbl[19] = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'd7,1'b1,32'd0, 1'b0,1'b1,3'd4,1'b1);
        tbl[20] = mk(1'b0,1'b0,1'b0,4'b0000,1'b1,3'd0,1'b1,32'd10,1'b0,1'b1,3'd4,1'b1);
        tbl[21] = mk(1'b0,1'b0,1'b0,4'b0000,1'b0,3'd0,1'b0,32'd10,1'b0,1'b1,3'd4,1'b1);

        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_valid", 64'(rd_valid_a), 64'd0);
        chk("rst_data", 64'(rd_data_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_running", 64'(running_a), 64'd0);
        chk("rst_hc", 64'(halt_cnt_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            start = tbl[i].start; clear = tbl[i].clear; retire = tbl[i].retire;
            halt = tbl[i].halt; evt = tbl[i].evt; rd_req = tbl[i].rd_req;
            rd_sel = tbl[i].rd_sel;
            step();
            chk($sformatf("v%0d_valid", i), 64'(rd_valid_a), 64'(tbl[i].exp_valid));
            chk($sformatf("v%0d_data", i), 64'(rd_data_a), 64'(tbl[i].exp_data));
            chk($sformatf("v%0d_running", i), 64'(running_a), 64'(tbl[i].exp_running));
            chk($sformatf("v%0d_done", i), 64'(done_a), 64'(tbl[i].exp_done));
            chk($sformatf("v%0d_hc", i), 64'(halt_cnt_a), 64'(tbl[i].exp_hc));
            chk($sformatf("v%0d_done_hl1", i), 64'(done_c), 64'(tbl[i].exp_done_c));
        end
        chk("run_ovf", 64'(ovf_a), 64'd0);

        // DONE is frozen: activity and start are ignored, reads stay stable
        for (int i = 0; i < 20; i++) begin
            start = 1'b1; retire = 1'b1; halt = 1'b1; evt = 4'b1111;
            rd_req = 1'b1; rd_sel = 3'(i % 6);
            step();
            chk($sformatf("done_rd%0d", i), 64'(rd_data_a), 64'(fin[i % 6]));
            chk($sformatf("done_flag%0d", i), 64'(done_a), 64'd1);
        end
        chk("done_hc", 64'(halt_cnt_a), 64'd4);
        chk("done_ovf", 64'(ovf_a), 64'd0);

        // clear beats start/halt; same-cycle read sees pre-clear value
        idle_inputs();
        clear = 1'b1; start = 1'b1; halt = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
        step();
        chk("clr_rd_pre", 64'(rd_data_a), 64'd10);
        chk("clr_valid", 64'(rd_valid_a), 64'd1);
        chk("clr_done", 64'(done_a), 64'd0);
        chk("clr_running", 64'(running_a), 64'd0);
        chk("clr_hc", 64'(halt_cnt_a), 64'd0);
        idle_inputs();
        rd_req = 1'b1; rd_sel = 3'd0;
        step();
        chk("clr_rd_post", 64'(rd_data_a), 64'd0);
        idle_inputs();
        start = 1'b1;
        step();
        idle_inputs();
        halt = 1'b1;
        step();
        chk("run_hc1", 64'(halt_cnt_a), 64'd1);
        clear = 1'b1; start = 1'b1; halt = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
        step();
        chk("clr_run_rd", 64'(rd_data_a), 64'd1);
        chk("clr_run_hc", 64'(halt_cnt_a), 64'd0);
        chk("clr_run_running", 64'(running_a), 64'd0);
        idle_inputs();
        step();
        chk("clr_run_idle", 64'(running_a), 64'd0);

        // saturation on the 4-bit instance
        start = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            evt = 4'b0001;
            step();
        end
        idle_inputs();
        chk("sat_ovf_b", 64'(ovf_b), 64'h05);
        chk("sat_ovf_a", 64'(ovf_a), 64'd0);
        rd_req = 1'b1; rd_sel = 3'd2;
        step();
        chk("sat_rd_b", 64'(rd_data_b), 64'd15);
        chk("sat_rd_a", 64'(rd_data_a), 64'd20);
        idle_inputs();
        clear = 1'b1;
        step();
        chk("sat_clr_ovf_b", 64'(ovf_b), 64'd0);
        idle_inputs();
        rd_req = 1'b1; rd_sel = 3'd2;
        step();
        chk("sat_clr_rd_b", 64'(rd_data_b), 64'd0);

        // asynchronous reset mid-run with a read in flight
        idle_inputs();
        start = 1'b1;
        step();
        idle_inputs();
        retire = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rd_req = 1'b1; rd_sel = 3'd0;
        step();
        chk("ar_pre_valid", 64'(rd_valid_a), 64'd1);
        chk("ar_pre_data", 64'(rd_data_a), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 64'(rd_valid_a), 64'd0);
        chk("ar_data", 64'(rd_data_a), 64'd0);
        chk("ar_running", 64'(running_a), 64'd0);
        chk("ar_done", 64'(done_a), 64'd0);
        chk("ar_hc", 64'(halt_cnt_a), 64'd0);
        step();
        chk("ar_hold_valid", 64'(rd_valid_a), 64'd0);
        #2 rst = 1'b1;
        idle_inputs();
        step();
        chk("ar_idle_running", 64'(running_a), 64'd0);
        chk("ar_idle_valid", 64'(rd_valid_a), 64'd0);
        rd_req = 1'b1; rd_sel = 3'd0;
        step();
        chk("ar_rd_cycles", 64'(rd_data_a), 64'd0);
        chk("ar_rd_valid", 64'(rd_valid_a), 64'd1);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
